// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: character RAM -> font ROM -> colour, as a 3-stage pipeline
// that produces one pixel per clock, three cycles after it is requested.
module text_pixel_gen #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 45,
    parameter logic [23:0] FG_RGB = 24'h33FF33,
    parameter logic [23:0] BG_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] current_x,
    input  logic [10:0] current_y,
    input  logic        request,
    output logic [11:0] cram_addr,
    input  logic [7:0]  cram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [6:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    input  logic        cursor_en,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [5:0]  frame_cnt
);

    localparam logic [11:0] COLS_W = 12'(COLS);

    logic [6:0]  col_in;
    logic [5:0]  row_in;
    logic        in_range;
    logic        cursor_hit_in;
    logic        frame_tick;
    logic        req_prev;
    logic [11:0] addr_in;
    logic        pix_p2;
    logic        unused_x0;

    logic        vld_p0, vld_p1;
    logic [3:0]  line_p0, line_p1;
    logic [2:0]  bitsel_p0, bitsel_p1;
    logic        cur_p0, cur_p1;
    logic        inv_p1;
    logic [23:0] rgb_p2;

    function automatic logic [23:0] pixel_colour(input logic vld, input logic pix);
        if (!vld)
            return 24'h000000;
        return pix ? FG_RGB : BG_RGB;
    endfunction

    // Each font bit covers two screen pixels, so x[0] never selects anything.
    assign unused_x0     = current_x[0];
    assign col_in        = current_x[10:4];
    assign row_in        = current_y[9:4];
    assign in_range      = !current_y[10] && (32'(col_in) < COLS) && (32'(row_in) < ROWS);
    assign addr_in       = 12'(row_in) * COLS_W + 12'(col_in);
    assign cursor_hit_in = cursor_en && (col_in == cursor_col) && (row_in == cursor_row)
                           && frame_cnt[5];
    assign frame_tick    = request && (current_x == 11'd0) && (current_y == 11'd0) && !req_prev;
    assign pix_p2        = font_data[3'd7 - bitsel_p1] ^ inv_p1
                           ^ (cur_p1 && (line_p1 >= 4'd14));
    assign {r, g, b}     = rgb_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_prev  <= 1'b0;
            frame_cnt <= 6'd0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            cram_addr <= 12'd0;
            font_addr <= 11'd0;
            rgb_p2    <= 24'h000000;
        end else begin
            req_prev  <= request;
            if (frame_tick)
                frame_cnt <= frame_cnt + 6'd1;
            // stage 0: cell coordinates, character RAM address
            vld_p0    <= request && in_range;
            cram_addr <= addr_in;
            // stage 1: glyph line address
            vld_p1    <= vld_p0;
            font_addr <= {cram_data[6:0], line_p0};
            // stage 2: pixel select and colour
            rgb_p2    <= pixel_colour(vld_p1, pix_p2);
        end
    end

    always_ff @(posedge clk) begin
        line_p0   <= current_y[3:0];
        bitsel_p0 <= current_x[3:1];
        cur_p0    <= cursor_hit_in;
        line_p1   <= line_p0;
        bitsel_p1 <= bitsel_p0;
        cur_p1    <= cur_p0;
        inv_p1    <= cram_data[7];
    end

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen: addressing, glyph/inverse/cursor colouring,
// range blanking, frame counter and reset behaviour.
module tb_text_pixel_gen;

    localparam logic [23:0] FG = 24'h33FF33;
    localparam logic [23:0] BG = 24'h000000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] current_x, current_y;
    logic        request;
    logic [11:0] cram_addr;
    logic [7:0]  cram_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        cursor_en;
    logic [7:0]  r, g, b;
    logic [5:0]  frame_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] got [0:31];

    text_pixel_gen dut (
        .clk(clk), .reset_n(reset_n), .current_x(current_x), .current_y(current_y),
        .request(request), .cram_addr(cram_addr), .cram_data(cram_data),
        .font_addr(font_addr), .font_data(font_data), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .cursor_en(cursor_en), .r(r), .g(g), .b(b),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Streams n consecutive pixels on line y starting at x0; got[i] holds pixel i's colour.
    task automatic run_line(input logic [10:0] y, input logic [10:0] x0, input int n);
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (i >= 3) got[i-3] = {r, g, b};
            if (i < n) begin
                request   = 1'b1;
                current_x = 11'(x0 + 11'(i));
                current_y = y;
            end else begin
                request = 1'b0;
            end
        end
    endtask

    task automatic frame_tick_pulse();
        @(negedge clk);
        request = 1'b1; current_x = 11'd0; current_y = 11'd0;
        @(negedge clk);
        request = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; request = 1'b0; current_x = 11'd0; current_y = 11'd0;
        cram_data = 8'h00; font_data = 8'h00;
        cursor_col = 7'd0; cursor_row = 6'd0; cursor_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({r, g, b} !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=%h", {r, g, b}, 24'h0); end
        checks++; if (cram_addr !== 12'd0) begin failures++; $display("FAIL reset_cram_addr got=%0d exp=0", cram_addr); end
        checks++; if (font_addr !== 11'd0) begin failures++; $display("FAIL reset_font_addr got=%0d exp=0", font_addr); end
        checks++; if (frame_cnt !== 6'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if ({r, g, b} !== 24'h0) begin failures++; $display("FAIL post_reset_rgb got=%h exp=%h", {r, g, b}, 24'h0); end
    endtask

    task automatic test_address();
        logic [10:0] xs [0:2];
        logic [10:0] ys [0:2];
        logic [11:0] exp_addr [0:2];
        xs = '{11'd1279, 11'd16, 11'd80};
        ys = '{11'd719, 11'd16, 11'd48};
        exp_addr = '{12'd3599, 12'd81, 12'd245};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            request = 1'b1; current_x = xs[i]; current_y = ys[i];
            @(negedge clk);
            request = 1'b0;
            checks++;
            if (cram_addr !== exp_addr[i]) begin
                failures++; $display("FAIL cram_addr[%0d] got=%0d exp=%0d", i, cram_addr, exp_addr[i]);
            end
        end
    endtask

    task automatic test_glyph();
        cram_data = 8'h41; font_data = 8'h80;
        @(negedge clk);
        request = 1'b1; current_x = 11'd0; current_y = 11'd37;
        @(negedge clk);
        request = 1'b0;
        @(negedge clk);
        checks++; if (font_addr !== 11'h415) begin failures++; $display("FAIL font_addr got=%h exp=%h", font_addr, 11'h415); end
        run_line(11'd37, 11'd0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== ((i < 2) ? FG : BG)) begin
                failures++; $display("FAIL glyph x=%0d got=%h exp=%h", i, got[i], (i < 2) ? FG : BG);
            end
        end
    endtask

    task automatic test_inverse();
        cram_data = 8'hC1; font_data = 8'h80;
        run_line(11'd37, 11'd0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== ((i < 2) ? BG : FG)) begin
                failures++; $display("FAIL inverse x=%0d got=%h exp=%h", i, got[i], (i < 2) ? BG : FG);
            end
        end
    endtask

    task automatic test_out_of_range();
        cram_data = 8'h01; font_data = 8'hFF;
        run_line(11'd719, 11'd1279, 2);
        checks++; if (got[0] !== FG) begin failures++; $display("FAIL range_last_col got=%h exp=%h", got[0], FG); end
        checks++; if (got[1] !== 24'h0) begin failures++; $display("FAIL range_col80 got=%h exp=%h", got[1], 24'h0); end
        run_line(11'd720, 11'd16, 1);
        checks++; if (got[0] !== 24'h0) begin failures++; $display("FAIL range_row45 got=%h exp=%h", got[0], 24'h0); end
    endtask

    task automatic test_cursor();
        cram_data = 8'h01; font_data = 8'h00;
        cursor_col = 7'd5; cursor_row = 6'd3; cursor_en = 1'b1;
        repeat (32) frame_tick_pulse();
        @(negedge clk);
        checks++; if (frame_cnt !== 6'd32) begin failures++; $display("FAIL frame_cnt_32 got=%0d exp=32", frame_cnt); end
        run_line(11'd62, 11'd78, 20);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (got[i] !== ((i >= 2 && i <= 17) ? FG : BG)) begin
                failures++; $display("FAIL cursor_on x=%0d got=%h exp=%h", 78 + i, got[i], (i >= 2 && i <= 17) ? FG : BG);
            end
        end
        run_line(11'd63, 11'd95, 1);
        checks++; if (got[0] !== FG) begin failures++; $display("FAIL cursor_line15 got=%h exp=%h", got[0], FG); end
        run_line(11'd61, 11'd80, 2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got[i] !== BG) begin failures++; $display("FAIL cursor_line13 x=%0d got=%h exp=%h", 80 + i, got[i], BG); end
        end
        repeat (32) frame_tick_pulse();
        @(negedge clk);
        checks++; if (frame_cnt !== 6'd0) begin failures++; $display("FAIL frame_wrap got=%0d exp=0", frame_cnt); end
        run_line(11'd62, 11'd80, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== BG) begin failures++; $display("FAIL cursor_off x=%0d got=%h exp=%h", 80 + i, got[i], BG); end
        end
        cursor_en = 1'b0;
    endtask

    task automatic test_frame_hold();
        @(negedge clk);
        request = 1'b1; current_x = 11'd0; current_y = 11'd0;
        @(negedge clk);
        @(negedge clk);
        request = 1'b0;
        @(negedge clk);
        checks++; if (frame_cnt !== 6'd1) begin failures++; $display("FAIL frame_hold got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_reset_midstream();
        cram_data = 8'h01; font_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            request = 1'b1; current_x = 11'(16 + i); current_y = 11'd16;
        end
        @(negedge clk);
        checks++; if ({r, g, b} !== FG) begin failures++; $display("FAIL stream_active got=%h exp=%h", {r, g, b}, FG); end
        current_x = 11'd21;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({r, g, b} !== 24'h0) begin failures++; $display("FAIL midreset_rgb got=%h exp=%h", {r, g, b}, 24'h0); end
        checks++; if (cram_addr !== 12'd0) begin failures++; $display("FAIL midreset_cram_addr got=%0d exp=0", cram_addr); end
        checks++; if (frame_cnt !== 6'd0) begin failures++; $display("FAIL midreset_frame_cnt got=%0d exp=0", frame_cnt); end
        @(negedge clk);
        reset_n = 1'b1; request = 1'b0;
        @(negedge clk);
        checks++; if ({r, g, b} !== 24'h0) begin failures++; $display("FAIL idle_after_reset got=%h exp=%h", {r, g, b}, 24'h0); end
        @(negedge clk);
        request = 1'b1; current_x = 11'd32; current_y = 11'd16;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if ({r, g, b} !== ((i == 3) ? FG : 24'h0)) begin
                failures++; $display("FAIL first_pixel t+%0d got=%h exp=%h", i, {r, g, b}, (i == 3) ? FG : 24'h0);
            end
        end
        request = 1'b0;
    endtask

    initial begin
        test_reset();
        test_address();
        test_glyph();
        test_inverse();
        test_out_of_range();
        test_cursor();
        test_frame_hold();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
